// File: rtl/addsub_accum_ctrl_if.sv
// rtl/addsub_accum_ctrl_if.sv - command/response bundle for the add/sub accumulator
interface addsub_accum_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] acc;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic [7:0]       op_cnt;

   modport master (
      output in_valid, op, operand, out_ready,
      input  in_ready, out_valid, acc, cout, ovf, zero, op_cnt
   );

   modport slave (
      input  in_valid, op, operand, out_ready,
      output in_ready, out_valid, acc, cout, ovf, zero, op_cnt
   );
endinterface

// File: rtl/addsub_accum_ctrl.sv
// rtl/addsub_accum_ctrl.sv - three-state command FSM around an add/sub accumulator
module addsub_accum_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   addsub_accum_ctrl_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q;
   logic [7:0]       cnt_q;
   logic [WIDTH:0]   sum;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result uses only the captured command, never the live request inputs.
   always_comb begin
      sum    = '0;
      acc_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      case (op_q)
         OP_LOAD: acc_d = operand_q;
         OP_ADD: begin
            sum    = {1'b0, acc_q} + {1'b0, operand_q};
            acc_d  = sum[WIDTH-1:0];
            cout_d = sum[WIDTH];
            ovf_d  = (acc_q[MSB] == operand_q[MSB]) && (sum[MSB] != acc_q[MSB]);
         end
         OP_SUB: begin
            sum    = {1'b0, acc_q} + {1'b0, ~operand_q} + {{WIDTH{1'b0}}, 1'b1};
            acc_d  = sum[WIDTH-1:0];
            cout_d = ~sum[WIDTH];
            ovf_d  = (acc_q[MSB] != operand_q[MSB]) && (sum[MSB] != acc_q[MSB]);
         end
         default: acc_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= OP_LOAD;
         operand_q <= '0;
         acc_q     <= '0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b1;
         cnt_q     <= 8'd0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.in_valid) begin
            op_q      <= bus.op;
            operand_q <= bus.operand;
         end
         if (state_q == EXEC) begin
            acc_q  <= acc_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= (acc_d == '0);
            cnt_q  <= cnt_q + 8'd1;
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == RESP);
   assign bus.acc       = acc_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.op_cnt    = cnt_q;
endmodule
